// File: rtl/rsa_pkg.sv
// Shared types and timing helpers for the RSA modular-exponentiation engine.
package rsa_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    MUL_R  = 3'd2,
    MUL_B  = 3'd3,
    FINISH = 3'd4
  } rsa_state_e;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_EXP_WIDTH = 16;
  localparam int MUL_LAT       = DEF_WIDTH + 1;

  // Cycles from acceptance to the done pulse for any in-range operand set.
  function automatic int calc_lat(input int width, input int exp_width);
    return 2 * exp_width * (width + 1) + 2;
  endfunction

endpackage

// File: rtl/rsa_modmul.sv
// Modular multiplier p = a*b mod n, MSB-first interleaved shift-add.
// One load cycle plus WIDTH step cycles; requires a < n and b < n.
module rsa_modmul
  import rsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             done,
  output logic [WIDTH-1:0] p
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH:0]   acc_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] n_r;
  logic [CNT_W-1:0] cnt_r;
  logic             run_r;
  logic             done_r;

  logic [WIDTH+1:0] n_ext_s;
  logic [WIDTH+1:0] a_ext_s;
  logic [WIDTH+1:0] t0_s;
  logic [WIDTH+1:0] t1_s;
  logic [WIDTH+1:0] t2_s;
  logic [WIDTH:0]   t3_s;

  // One shift-add step; every intermediate stays below 2n so WIDTH+2 bits suffice.
  always_comb begin
    n_ext_s = {2'b00, n_r};
    a_ext_s = {2'b00, a_r};
    t0_s    = {acc_r, 1'b0};
    if (t0_s >= n_ext_s) t1_s = t0_s - n_ext_s;
    else                 t1_s = t0_s;
    if (b_r[WIDTH-1]) t2_s = t1_s + a_ext_s;
    else              t2_s = t1_s;
    if (t2_s >= n_ext_s) t3_s = (WIDTH+1)'(t2_s - n_ext_s);
    else                 t3_s = (WIDTH+1)'(t2_s);
  end

  // Operand load on start, then one step per cycle until WIDTH bits are consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r  <= '0;
      a_r    <= '0;
      b_r    <= '0;
      n_r    <= '0;
      cnt_r  <= '0;
      run_r  <= 1'b0;
      done_r <= 1'b0;
    end else if (start) begin
      acc_r  <= '0;
      a_r    <= a;
      b_r    <= b;
      n_r    <= n;
      cnt_r  <= '0;
      run_r  <= 1'b1;
      done_r <= 1'b0;
    end else if (run_r) begin
      acc_r  <= t3_s;
      b_r    <= {b_r[WIDTH-2:0], 1'b0};
      cnt_r  <= cnt_r + CNT_W'(1);
      done_r <= (cnt_r == CNT_W'(WIDTH - 1));
      run_r  <= (cnt_r != CNT_W'(WIDTH - 1));
    end else begin
      done_r <= 1'b0;
    end
  end

  assign done = done_r;
  assign p    = acc_r[WIDTH-1:0];

endmodule

// File: rtl/rsa_modexp_engine.sv
// Constant-time left-to-right-free (LSB-first) square-and-multiply RSA engine.
// Every exponent bit costs one R*B and one B*B multiply regardless of its value.
module rsa_modexp_engine
  import rsa_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int EXP_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     msg,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     modulus,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [WIDTH-1:0]     result
);

  localparam int IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

  rsa_state_e           state_r;
  rsa_state_e           state_nx_s;
  logic [WIDTH-1:0]     msg_r;
  logic [EXP_WIDTH-1:0] exp_r;
  logic [WIDTH-1:0]     n_r;
  logic [WIDTH-1:0]     r_r;
  logic [WIDTH-1:0]     b_r;
  logic [IDX_W-1:0]     idx_r;
  logic                 err_r;
  logic [WIDTH-1:0]     result_r;
  logic                 done_r;
  logic                 ready_r;

  logic                 operand_bad_s;
  logic                 last_bit_s;
  logic                 mul_start_s;
  logic [WIDTH-1:0]     mul_a_s;
  logic [WIDTH-1:0]     mul_b_s;
  logic                 mul_done_s;
  logic [WIDTH-1:0]     mul_p_s;

  assign operand_bad_s = (n_r < WIDTH'(2)) || (msg_r >= n_r);
  assign last_bit_s    = (idx_r == IDX_W'(EXP_WIDTH - 1));

  // Next multiply is launched in the cycle the previous one completes, so each
  // multiply state lasts exactly WIDTH+1 cycles; operands bypass the registers
  // that are being updated on that same edge.
  always_comb begin
    state_nx_s  = state_r;
    mul_start_s = 1'b0;
    mul_a_s     = r_r;
    mul_b_s     = b_r;
    case (state_r)
      IDLE: begin
        if (start && ready_r) state_nx_s = CHECK;
        else                  state_nx_s = IDLE;
      end
      CHECK: begin
        if (operand_bad_s) begin
          state_nx_s = FINISH;
        end else begin
          state_nx_s  = MUL_R;
          mul_start_s = 1'b1;
          mul_a_s     = WIDTH'(1);
          mul_b_s     = msg_r;
        end
      end
      MUL_R: begin
        if (mul_done_s) begin
          state_nx_s  = MUL_B;
          mul_start_s = 1'b1;
          mul_a_s     = b_r;
          mul_b_s     = b_r;
        end else begin
          state_nx_s  = MUL_R;
        end
      end
      MUL_B: begin
        if (mul_done_s && last_bit_s) begin
          state_nx_s  = FINISH;
        end else if (mul_done_s) begin
          state_nx_s  = MUL_R;
          mul_start_s = 1'b1;
          mul_a_s     = r_r;
          mul_b_s     = mul_p_s;
        end else begin
          state_nx_s  = MUL_B;
        end
      end
      FINISH:  state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State register plus operand capture, accumulator commits and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      msg_r    <= '0;
      exp_r    <= '0;
      n_r      <= '0;
      r_r      <= '0;
      b_r      <= '0;
      idx_r    <= '0;
      err_r    <= 1'b0;
      result_r <= '0;
      done_r   <= 1'b0;
      ready_r  <= 1'b1;
    end else begin
      state_r <= state_nx_s;
      done_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start && ready_r) begin
            msg_r    <= msg;
            exp_r    <= exponent;
            n_r      <= modulus;
            err_r    <= 1'b0;
            result_r <= '0;
            ready_r  <= 1'b0;
          end else if (done_r) begin
            ready_r  <= 1'b1;
          end
        end
        CHECK: begin
          if (operand_bad_s) begin
            err_r <= 1'b1;
          end else begin
            r_r   <= WIDTH'(1);
            b_r   <= msg_r;
            idx_r <= '0;
          end
        end
        MUL_R: begin
          if (mul_done_s && exp_r[idx_r]) r_r <= mul_p_s;
        end
        MUL_B: begin
          if (mul_done_s) begin
            b_r   <= mul_p_s;
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        FINISH: begin
          done_r   <= 1'b1;
          result_r <= err_r ? '0 : r_r;
        end
        default: ;
      endcase
    end
  end

  rsa_modmul #(.WIDTH(WIDTH)) u_modmul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start_s),
    .a     (mul_a_s),
    .b     (mul_b_s),
    .n     (n_r),
    .done  (mul_done_s),
    .p     (mul_p_s)
  );

  assign ready  = ready_r;
  assign busy   = ~ready_r;
  assign done   = done_r;
  assign error  = err_r;
  assign result = result_r;

endmodule

// File: tb/tb_rsa_modexp_engine.sv
// Directed-vector bench for rsa_modexp_engine at WIDTH=16, EXP_WIDTH=16.
module tb_rsa_modexp_engine;
  import rsa_pkg::*;

  localparam int W   = 16;
  localparam int EW  = 16;
  localparam int LAT = calc_lat(W, EW);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  msg = '0;
  logic [EW-1:0] exponent = '0;
  logic [W-1:0]  modulus = '0;
  logic          ready, busy, done, error;
  logic [W-1:0]  result;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  rsa_modexp_engine #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .msg(msg), .exponent(exponent),
    .modulus(modulus), .ready(ready), .busy(busy), .done(done), .error(error),
    .result(result)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic run_op(input logic [W-1:0] m, input logic [EW-1:0] e, input logic [W-1:0] n,
                        output int lat, output logic [W-1:0] res, output logic err);
    int g;
    g = 0;
    while (ready !== 1'b1 && g < 2000) begin
      @(posedge clk); #1; g++;
    end
    if (ready !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_wait: ready=%b required 1", ready);
    end
    msg = m; exponent = e; modulus = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (lat < LAT + 20) begin
      @(posedge clk); #1; lat++;
      if (done === 1'b1) break;
    end
    res = result;
    err = error;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp += 5;
    if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b required 1", ready); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b required 0", busy); end
    if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b required 0", done); end
    if (error !== 1'b0) begin n_bad++; $display("FAIL reset_error: got %b required 0", error); end
    if (result !== 16'd0) begin n_bad++; $display("FAIL reset_result: got %0d required 0", result); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat; logic [W-1:0] res; logic err;
    run_op(16'd65, 16'd17, 16'd3233, lat, res, err);
    n_cmp += 3;
    if (res !== 16'd2790) begin n_bad++; $display("FAIL basic_result: got %0d required 2790", res); end
    if (err !== 1'b0) begin n_bad++; $display("FAIL basic_error: got %b required 0", err); end
    if (lat !== 546) begin n_bad++; $display("FAIL basic_latency: got %0d required 546", lat); end
  endtask

  task automatic test_roundtrip();
    int lat; logic [W-1:0] res; logic err;
    run_op(16'd2790, 16'd2753, 16'd3233, lat, res, err);
    n_cmp += 2;
    if (res !== 16'd65) begin n_bad++; $display("FAIL decrypt_result: got %0d required 65", res); end
    if (lat !== 546) begin n_bad++; $display("FAIL decrypt_latency: got %0d required 546", lat); end
    run_op(16'd4, 16'd13, 16'd497, lat, res, err);
    n_cmp += 2;
    if (res !== 16'd445) begin n_bad++; $display("FAIL small_result: got %0d required 445", res); end
    if (lat !== 546) begin n_bad++; $display("FAIL small_latency: got %0d required 546", lat); end
  endtask

  task automatic test_edge_values();
    int lat; logic [W-1:0] res; logic err;
    run_op(16'd123, 16'd0, 16'd3233, lat, res, err);
    n_cmp += 2;
    if (res !== 16'd1) begin n_bad++; $display("FAIL exp_zero_result: got %0d required 1", res); end
    if (lat !== 546) begin n_bad++; $display("FAIL exp_zero_latency: got %0d required 546", lat); end
    run_op(16'd0, 16'd5, 16'd3233, lat, res, err);
    n_cmp += 2;
    if (res !== 16'd0) begin n_bad++; $display("FAIL msg_zero_result: got %0d required 0", res); end
    if (err !== 1'b0) begin n_bad++; $display("FAIL msg_zero_error: got %b required 0", err); end
  endtask

  task automatic test_errors();
    int lat; logic [W-1:0] res; logic err;
    run_op(16'd3233, 16'd5, 16'd3233, lat, res, err);
    n_cmp += 3;
    if (lat !== 2) begin n_bad++; $display("FAIL err_msg_latency: got %0d required 2", lat); end
    if (err !== 1'b1) begin n_bad++; $display("FAIL err_msg_error: got %b required 1", err); end
    if (res !== 16'd0) begin n_bad++; $display("FAIL err_msg_result: got %0d required 0", res); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (error !== 1'b1) begin n_bad++; $display("FAIL err_held: got %b required 1", error); end
    run_op(16'd0, 16'd7, 16'd1, lat, res, err);
    n_cmp += 3;
    if (lat !== 2) begin n_bad++; $display("FAIL err_mod_latency: got %0d required 2", lat); end
    if (err !== 1'b1) begin n_bad++; $display("FAIL err_mod_error: got %b required 1", err); end
    if (res !== 16'd0) begin n_bad++; $display("FAIL err_mod_result: got %0d required 0", res); end
    run_op(16'd4, 16'd13, 16'd497, lat, res, err);
    n_cmp += 2;
    if (err !== 1'b0) begin n_bad++; $display("FAIL err_cleared: got %b required 0", err); end
    if (res !== 16'd445) begin n_bad++; $display("FAIL err_recover_result: got %0d required 445", res); end
  endtask

  task automatic test_back_to_back();
    int lat; int base; int g;
    g = 0;
    while (ready !== 1'b1 && g < 2000) begin @(posedge clk); #1; g++; end
    base = done_cnt;
    msg = 16'd65; exponent = 16'd17; modulus = 16'd3233; start = 1'b1;
    @(posedge clk); #1;
    msg = 16'd4; exponent = 16'd13; modulus = 16'd497;
    lat = 0;
    while (lat < LAT + 20) begin
      @(posedge clk); #1; lat++;
      if (done === 1'b1) break;
    end
    n_cmp += 3;
    if (lat !== 546) begin n_bad++; $display("FAIL b2b_first_latency: got %0d required 546", lat); end
    if (result !== 16'd2790) begin n_bad++; $display("FAIL b2b_first_result: got %0d required 2790", result); end
    if (ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_in_done: got %b required 0", ready); end
    @(posedge clk); #1;
    n_cmp += 2;
    if (ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_after_done: got %b required 1", ready); end
    if (done !== 1'b0) begin n_bad++; $display("FAIL b2b_done_single: got %b required 0", done); end
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_second_accept: busy=%b required 1", busy); end
    lat = 0;
    while (lat < LAT + 20) begin
      @(posedge clk); #1; lat++;
      if (done === 1'b1) break;
      if (lat % 100 == 50) begin start = 1'b1; msg = 16'd9; exponent = 16'd3; modulus = 16'd11; end
      else start = 1'b0;
    end
    start = 1'b0;
    n_cmp += 2;
    if (lat !== 546) begin n_bad++; $display("FAIL b2b_second_latency: got %0d required 546", lat); end
    if (result !== 16'd445) begin n_bad++; $display("FAIL b2b_second_result: got %0d required 445", result); end
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (done_cnt - base !== 2) begin n_bad++; $display("FAIL b2b_done_count: got %0d required 2", done_cnt - base); end
  endtask

  task automatic test_reset_mid();
    int lat; int base; logic [W-1:0] res; logic err;
    msg = 16'd65; exponent = 16'd17; modulus = 16'd3233; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (200) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp += 4;
    if (ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready: got %b required 1", ready); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b required 0", busy); end
    if (done !== 1'b0) begin n_bad++; $display("FAIL midrst_done: got %b required 0", done); end
    if (result !== 16'd0) begin n_bad++; $display("FAIL midrst_result: got %0d required 0", result); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    base = done_cnt;
    repeat (600) @(posedge clk);
    #1;
    n_cmp++;
    if (done_cnt !== base) begin n_bad++; $display("FAIL midrst_no_done: got %0d pulses required 0", done_cnt - base); end
    run_op(16'd65, 16'd17, 16'd3233, lat, res, err);
    n_cmp += 2;
    if (res !== 16'd2790) begin n_bad++; $display("FAIL midrst_restart_result: got %0d required 2790", res); end
    if (lat !== 546) begin n_bad++; $display("FAIL midrst_restart_latency: got %0d required 546", lat); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_roundtrip();
    test_edge_values();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rsa_modexp_engine.md
Name: rsa_modexp_engine

Overview:
Parametrised, constant-time RSA modular-exponentiation engine computing result = msg^exponent mod modulus. It is the next generation of the fixed 8-bit-in/16-bit-out RSA controller+datapath pair, generalised in operand widths. It adds a start/ready/done handshake, operand-error detection and data-independent latency. Sits between the message source and the output sink, with one instance per channel.

Parameters:
WIDTH, 16, bit width of msg, modulus and result (minimum 4)
EXP_WIDTH, 16, bit width of exponent (minimum 1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only on a cycle where start && ready
msg  input  WIDTH  plaintext/ciphertext, sampled at acceptance
exponent  input  EXP_WIDTH  public or private exponent, sampled at acceptance
modulus  input  WIDTH  modulus n, sampled at acceptance
ready  output  1  engine idle, can accept start
busy  output  1  operation in progress (equals !ready)
done  output  1  one-cycle pulse: result/error valid
error  output  1  operand error for last operation; valid with done, held until next acceptance
result  output  WIDTH  last result; held until next acceptance

Behaviour:
- Clock/reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values: ready=1, busy=0, done=0, error=0, result=0, FSM in IDLE. Reset mid-operation aborts the operation with no done pulse.
- Acceptance: start && ready at edge E0 latches msg, exponent and modulus, clears error and result, and moves IDLE->CHECK. Input changes after E0 are ignored. start while busy is ignored and not queued.
- CHECK state (1 cycle): error if modulus < 2 or msg >= modulus.
  - Error: go to FINISH with error=1, result=0. done pulses 2 cycles after E0.
  - Otherwise: R=1, B=msg, bit index i=0, go to MUL_R.
- MUL_R: R' = R*B mod n via sub-module. Computed every bit regardless of exponent[i] (constant time). Commit R=R' only if exponent[i]=1. Then go to MUL_B.
- MUL_B: B = B*B mod n. If i == EXP_WIDTH-1, go to FINISH; else i++ and go to MUL_R.
- FINISH (1 cycle): result <= R (or 0 on error), done=1, then go to IDLE. ready rises in the cycle after the done pulse.
- Latency: done pulses exactly LAT = 2*EXP_WIDTH*(WIDTH+1) + 2 cycles after E0 for every non-error operand. It is independent of exponent and msg values.
- Exponent = 0: result = 1 after the full LAT.
- Modular multiply (sub-module), MSB-first interleaved shift-add:
  - Requires a < n and b < n. Accumulator acc is WIDTH+1 bits; intermediates are WIDTH+2 bits.
  - Per step: acc = 2*acc; if acc >= n then acc -= n; if b[j] then acc += a; if acc >= n then acc -= n.
  - One load cycle plus WIDTH step cycles; its done asserts WIDTH+1 cycles after its start.
  - Output is always < n. No overflow is possible at any WIDTH.
- start asserted in the same cycle as done: not accepted (ready=0). Accepted on the following cycle if still high.

Decomposition:
- rsa_pkg: state enum (IDLE, CHECK, MUL_R, MUL_B, FINISH), localparam MUL_LAT = WIDTH+1, function calc_lat(WIDTH, EXP_WIDTH) used by both RTL assertions and the bench.
- Sub-module rsa_modmul (params WIDTH; ports clk, rst_n, start, a, b, n, done, p). Its own counter; one instance shared by MUL_R and MUL_B.

Test Plan:
- WIDTH=16, EXP_WIDTH=16: msg=65, exponent=17, modulus=3233 -> result=2790, error=0; done exactly 2*16*17+2=546 cycles after acceptance.
- Round trip: msg=2790, exponent=2753, modulus=3233 -> result=65. msg=4, exponent=13, modulus=497 -> result=445. Both take the same 546-cycle latency.
- Exponent=0, msg=123, modulus=3233 -> result=1 after 546 cycles. msg=0, exponent=5 -> result=0.
- Errors:
  - msg=3233, modulus=3233 -> done 2 cycles after acceptance, error=1, result=0.
  - modulus=1 -> same.
  - Next valid operation clears error.
- start pulsed while busy, and start held through done -> only the first request runs. Second accepted on the cycle after done; no extra done pulses.
- rst_n low at cycle 200 of an operation -> outputs return to reset values immediately, no done. A new start after release gives the correct result (2790).
